// File: rtl/fetch_decode_unit_if.sv
// fetch_decode_unit_if
// Groups the loader, instruction-memory and issue signals of the fetch/decode
// controller into one bundle.
//   master : the fetch/decode unit (drives memory address/write and issue side)
//   slave  : the environment (loader, memory model, datapath)
// Signals:
//   start, ld_en, ld_addr, ld_data : boot/loader controls
//   im_wr, im_a, im_d, im_q        : instruction memory port
//   ex_ready, zero, jmp_addr       : datapath accept handshake and branch inputs
//   valid, op_class, dr, sa, sb,
//   reg_wr, mem_wr, illegal        : decoded instruction
//   pc, halted                     : program counter and run-off-end flag
interface fetch_decode_unit_if;
  logic        start;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [12:0] ld_data;
  logic        im_wr;
  logic [3:0]  im_a;
  logic [12:0] im_d;
  logic [12:0] im_q;
  logic        ex_ready;
  logic        zero;
  logic [3:0]  jmp_addr;
  logic        valid;
  logic [2:0]  op_class;
  logic [1:0]  dr;
  logic [1:0]  sa;
  logic [1:0]  sb;
  logic        reg_wr;
  logic        mem_wr;
  logic        illegal;
  logic [3:0]  pc;
  logic        halted;

  modport master (
    input  start, ld_en, ld_addr, ld_data, im_q, ex_ready, zero, jmp_addr,
    output im_wr, im_a, im_d, valid, op_class, dr, sa, sb,
           reg_wr, mem_wr, illegal, pc, halted
  );

  modport slave (
    output start, ld_en, ld_addr, ld_data, im_q, ex_ready, zero, jmp_addr,
    input  im_wr, im_a, im_d, valid, op_class, dr, sa, sb,
           reg_wr, mem_wr, illegal, pc, halted
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
// Owns the program counter, fetches 13-bit words from a 16-entry synchronous
// read instruction memory, decodes them and issues them to the datapath with
// a valid/ready handshake. A loader path writes the memory while idle.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : fetch_decode_unit_if.master (loader, memory port, issue outputs)
//
// state  | meaning
// IDLE   | waiting for start; loader writes allowed
// FETCH  | address PC presented to memory
// DECODE | memory word captured into IR
// ISSUE  | decoded instruction valid, waiting for ex_ready
module fetch_decode_unit (
  input logic             clk,
  input logic             rst,
  fetch_decode_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE} state_t;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_ADD   = 3'd1;
  localparam logic [2:0] C_DEC   = 3'd2;
  localparam logic [2:0] C_LOAD  = 3'd3;
  localparam logic [2:0] C_STORE = 3'd4;
  localparam logic [2:0] C_ADDI  = 3'd5;
  localparam logic [2:0] C_BRZ   = 3'd6;
  localparam logic [2:0] C_JUMP  = 3'd7;

  state_t      state, state_next;
  logic [3:0]  pc_q, pc_next;
  logic [12:0] ir_q, ir_next;
  logic        halted_q, halted_next;

  logic [6:0]  opcode;
  logic [2:0]  op_class_d;
  logic        illegal_d;
  logic        valid_d;
  logic        im_wr_d;
  logic [3:0]  im_a_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc_q     <= 4'd0;
      ir_q     <= 13'd0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_next;
      pc_q     <= pc_next;
      ir_q     <= ir_next;
      halted_q <= halted_next;
    end
  end

  assign opcode = ir_q[12:6];

  always_comb begin
    op_class_d = C_NOP;
    illegal_d  = 1'b0;
    case (opcode)
      7'b0000000: op_class_d = C_NOP;
      7'b0000010: op_class_d = C_ADD;
      7'b0000110: op_class_d = C_DEC;
      7'b0010000: op_class_d = C_LOAD;
      7'b0100000: op_class_d = C_STORE;
      7'b1000010: op_class_d = C_ADDI;
      7'b1100000: op_class_d = C_BRZ;
      7'b1110000: op_class_d = C_JUMP;
      default:    illegal_d  = 1'b1;
    endcase
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc_q;
    ir_next     = ir_q;
    halted_next = halted_q;
    im_wr_d     = 1'b0;
    im_a_d      = pc_q;
    valid_d     = 1'b0;
    case (state)
      S_IDLE: begin
        // a load request takes the memory port and shadows start
        if (bus.ld_en) begin
          im_wr_d = 1'b1;
          im_a_d  = bus.ld_addr;
        end else if (bus.start) begin
          pc_next     = 4'd0;
          halted_next = 1'b0;
          state_next  = S_FETCH;
        end
      end
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        ir_next    = bus.im_q;
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        valid_d = 1'b1;
        if (bus.ex_ready) begin
          state_next = S_FETCH;
          if (op_class_d == C_BRZ && bus.zero) begin
            pc_next = {ir_q[5:4], ir_q[1:0]};
          end else if (op_class_d == C_JUMP) begin
            pc_next = bus.jmp_addr;
          end else if (pc_q == 4'hF) begin
            // sequential advance past the last word stops instead of wrapping
            pc_next     = 4'd0;
            halted_next = 1'b1;
            state_next  = S_IDLE;
          end else begin
            pc_next = pc_q + 4'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.im_wr    = im_wr_d;
  assign bus.im_a     = im_a_d;
  assign bus.im_d     = bus.ld_data;
  assign bus.valid    = valid_d;
  assign bus.op_class = op_class_d;
  assign bus.dr       = ir_q[5:4];
  assign bus.sa       = ir_q[3:2];
  assign bus.sb       = ir_q[1:0];
  assign bus.reg_wr   = valid_d && (op_class_d == C_ADD || op_class_d == C_DEC ||
                                    op_class_d == C_LOAD || op_class_d == C_ADDI);
  assign bus.mem_wr   = valid_d && (op_class_d == C_STORE);
  assign bus.illegal  = valid_d && illegal_d;
  assign bus.pc       = pc_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
module tb_fetch_decode_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_decode_unit_if bus ();
  fetch_decode_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // instruction memory: synchronous write and synchronous read
  logic [12:0] mem_hw [16];
  always @(posedge clk) begin
    if (bus.im_wr) mem_hw[bus.im_a] <= bus.im_d;
    bus.im_q <= mem_hw[bus.im_a];
  end

  int          n_assert = 0;
  int          n_fail = 0;
  logic [12:0] mem_m [16];
  bit          st_zero [64];
  logic [3:0]  st_jmp [64];
  int          st_stall [64];
  bit          ld_noise;
  logic [6:0]  op_tbl [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_class(input logic [12:0] w);
    case (w[12:6])
      7'b0000010: return 1;
      7'b0000110: return 2;
      7'b0010000: return 3;
      7'b0100000: return 4;
      7'b1000010: return 5;
      7'b1100000: return 6;
      7'b1110000: return 7;
      default:    return 0;
    endcase
  endfunction

  // next PC after accepting word w at pc; 16 means the program ran off the end
  function automatic int model_next(input int pc, input logic [12:0] w, input bit z, input logic [3:0] j);
    int cls = model_class(w);
    if (cls == 6 && z) return int'(w[5:4]) * 4 + int'(w[1:0]);
    if (cls == 7) return int'(j);
    return pc + 1;
  endfunction

  function automatic logic [12:0] rand_word();
    int sel = $urandom_range(0, 9);
    logic [6:0] op;
    if (sel < 8) op = op_tbl[sel];
    else op = 7'($urandom);
    return {op, 6'($urandom)};
  endfunction

  task automatic clear_steps();
    for (int s = 0; s < 64; s++) begin
      st_zero[s] = 1'b0;
      st_jmp[s] = 4'd0;
      st_stall[s] = 0;
    end
  endtask

  // called at a negedge; returns one negedge after the reset edge with rst released
  task automatic do_reset();
    rst = 1'b1;
    bus.ex_ready = 1'b1;
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.valid), 32'(0));
    chk("rst_pc", 32'(bus.pc), 32'(0));
    chk("rst_im_a", 32'(bus.im_a), 32'(0));
    chk("rst_im_wr", 32'(bus.im_wr), 32'(0));
    chk("rst_halted", 32'(bus.halted), 32'(0));
    chk("rst_reg_wr", 32'(bus.reg_wr), 32'(0));
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'(0));
    chk("rst_illegal", 32'(bus.illegal), 32'(0));
    chk("rst_op_class", 32'(bus.op_class), 32'(0));
    rst = 1'b0;
    bus.ex_ready = 1'b0;
  endtask

  // called at a negedge with the DUT idle; write lands on the next edge
  task automatic load(input logic [3:0] a, input logic [12:0] d);
    bus.ld_en = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    #1;
    chk("ld_im_wr", 32'(bus.im_wr), 32'(1));
    chk("ld_im_a", 32'(bus.im_a), 32'(a));
    chk("ld_im_d", 32'(bus.im_d), 32'(d));
    mem_m[a] = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  // start execution and follow the model for up to max_steps accepts
  task automatic run_prog(input int max_steps);
    int cur = 0;
    int nxt;
    int cls;
    logic [12:0] w;
    bus.start = 1'b1;
    bus.ld_en = 1'b0;
    bus.ex_ready = 1'b0;
    for (int s = 0; s < max_steps; s++) begin
      w = mem_m[cur];
      cls = model_class(w);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        bus.ex_ready = 1'b0;
        bus.start = ld_noise ? 1'($urandom) : 1'b0;
        bus.ld_en = ld_noise;
        bus.ld_addr = 4'($urandom);
        bus.ld_data = 13'($urandom);
        #1;
        chk("run_im_wr", 32'(bus.im_wr), 32'(0));
        chk("run_valid", 32'(bus.valid), 32'(k == 3));
        chk("run_pc", 32'(bus.pc), 32'(cur));
        if (k == 1) chk("fetch_im_a", 32'(bus.im_a), 32'(cur));
      end
      chk("iss_op_class", 32'(bus.op_class), 32'(cls));
      chk("iss_dr", 32'(bus.dr), 32'(w[5:4]));
      chk("iss_sa", 32'(bus.sa), 32'(w[3:2]));
      chk("iss_sb", 32'(bus.sb), 32'(w[1:0]));
      chk("iss_reg_wr", 32'(bus.reg_wr), 32'(cls == 1 || cls == 2 || cls == 3 || cls == 5));
      chk("iss_mem_wr", 32'(bus.mem_wr), 32'(cls == 4));
      chk("iss_illegal", 32'(bus.illegal), 32'(cls == 0 && w[12:6] != 7'd0));
      chk("iss_halted", 32'(bus.halted), 32'(0));
      for (int t = 0; t < st_stall[s]; t++) begin
        @(negedge clk);
        #1;
        chk("stall_valid", 32'(bus.valid), 32'(1));
        chk("stall_pc", 32'(bus.pc), 32'(cur));
        chk("stall_im_a", 32'(bus.im_a), 32'(cur));
        chk("stall_op_class", 32'(bus.op_class), 32'(cls));
        chk("stall_mem_wr", 32'(bus.mem_wr), 32'(cls == 4));
      end
      bus.ex_ready = 1'b1;
      bus.zero = st_zero[s];
      bus.jmp_addr = st_jmp[s];
      nxt = model_next(cur, w, st_zero[s], st_jmp[s]);
      if (nxt == 16) begin
        @(negedge clk);
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
        bus.ex_ready = 1'b0;
        #1;
        chk("halt_valid", 32'(bus.valid), 32'(0));
        chk("halt_halted", 32'(bus.halted), 32'(1));
        chk("halt_pc", 32'(bus.pc), 32'(0));
        chk("halt_im_wr", 32'(bus.im_wr), 32'(0));
        return;
      end
      cur = nxt;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    bus.ex_ready = 1'b0;
    #1;
    chk("next_pc", 32'(bus.pc), 32'(cur));
    chk("next_im_a", 32'(bus.im_a), 32'(cur));
    chk("next_valid", 32'(bus.valid), 32'(0));
  endtask

  initial begin
    op_tbl[0] = 7'b0000010; op_tbl[1] = 7'b0000110; op_tbl[2] = 7'b0010000;
    op_tbl[3] = 7'b0100000; op_tbl[4] = 7'b1000010; op_tbl[5] = 7'b1100000;
    op_tbl[6] = 7'b1110000; op_tbl[7] = 7'b0000000;
    bus.start = 1'b0; bus.ld_en = 1'b0; bus.ld_addr = 4'd0; bus.ld_data = 13'd0;
    bus.ex_ready = 1'b0; bus.zero = 1'b0; bus.jmp_addr = 4'd0;
    ld_noise = 1'b0;
    clear_steps();
    @(negedge clk);
    do_reset();

    // ADD r3,r3,r0 then sequential advance to 1
    load(4'd0, 13'b0000010_11_11_00);
    run_prog(1);
    do_reset();

    // BRZ taken and not taken
    load(4'd0, 13'b1100000_10_01_11);
    st_zero[0] = 1'b1;
    run_prog(1);
    do_reset();
    st_zero[0] = 1'b0;
    run_prog(1);
    do_reset();

    // JUMP via jmp_addr
    load(4'd0, 13'b1110000_00_10_00);
    st_jmp[0] = 4'd5;
    run_prog(1);
    do_reset();
    clear_steps();

    // STORE with a 4-cycle stall
    load(4'd0, 13'b0100000_00_10_11);
    st_stall[0] = 4;
    run_prog(1);
    do_reset();
    clear_steps();

    // NOP program running off the end, then illegal opcode restarts from halt
    for (int a = 0; a < 16; a++) load(4'(a), 13'd0);
    run_prog(20);
    load(4'd0, 13'b1111111_01_10_11);
    run_prog(1);
    do_reset();
    run_prog(20);
    do_reset();

    // reset in ISSUE with ex_ready high
    load(4'd0, 13'b0000010_11_11_00);
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    chk("pre_rst_valid", 32'(bus.valid), 32'(1));
    do_reset();

    // loader requests and start pulses while executing are ignored
    load(4'd0, 13'b0000010_01_10_11);
    load(4'd1, 13'b0100000_00_10_11);
    load(4'd2, 13'b1110000_00_00_00);
    ld_noise = 1'b1;
    run_prog(3);
    do_reset();

    // random programs against the model
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 16; a++) load(4'(a), rand_word());
      for (int s = 0; s < 64; s++) begin
        st_zero[s] = 1'($urandom);
        st_jmp[s] = 4'($urandom);
        st_stall[s] = $urandom_range(0, 2);
      end
      ld_noise = it[0];
      run_prog(30);
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Instruction fetch and decode controller that sits directly downstream of the 16 x 13-bit synchronous-read instruction memory. It owns the program counter, drives the memory address/write port, and captures each returned 13-bit word. It decodes the word into register fields and control strobes, and issues it to the datapath with a valid/ready handshake. A loader path lets the testbench or boot logic write the memory before execution starts.

## Interface
- No parameters; widths fixed: address 4, instruction 13, register field 2.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin execution at PC=0; sampled only in IDLE.
- LD_EN  in  1  loader write request; honoured only in IDLE.
- LD_ADDR  in  4  loader write address.
- LD_DATA  in  13  loader write data.
- IM_WR  out  1  to memory WR.
- IM_A  out  4  to memory A.
- IM_D  out  13  to memory D_IN; always equals LD_DATA.
- IM_Q  in  13  from memory Q; valid one cycle after IM_A is presented with IM_WR=0.
- EX_READY  in  1  datapath accepts the issued instruction.
- ZERO  in  1  datapath flag: R[SA]==0; sampled on the accept edge.
- JMP_ADDR  in  4  low 4 bits of R[SA]; sampled on the accept edge.
- VALID  out  1  decoded instruction present.
- OP_CLASS  out  3  0 NOP/illegal, 1 ADD, 2 DEC, 3 LOAD, 4 STORE, 5 ADDI, 6 BRZ, 7 JUMP.
- DR, SA, SB  out  2 each  IR[5:4], IR[3:2], IR[1:0].
- REG_WR  out  1  ADD, DEC, LOAD or ADDI, gated by VALID.
- MEM_WR  out  1  STORE, gated by VALID.
- ILLEGAL  out  1  IR opcode is unrecognised, gated by VALID.
- PC  out  4  current program counter.
- HALTED  out  1  program ran off the end of memory.

## Operation
- Opcode field: IR[12:6], full 7-bit match.
  - 0000010 ADD
  - 0000110 DEC
  - 0010000 LOAD
  - 0100000 STORE
  - 1000010 ADDI (immediate = SB, zero-extended)
  - 1100000 BRZ
  - 1110000 JUMP
  - 0000000 NOP
  - Any other opcode: OP_CLASS=0, ILLEGAL=1, treated as NOP.
- States: IDLE, FETCH, DECODE, ISSUE.
- IDLE:
  - With LD_EN=1: IM_WR=1 and IM_A=LD_ADDR combinationally, so the write lands on the same edge.
  - With LD_EN=0: IM_WR=0, IM_A=PC.
  - START=1 with LD_EN=0: PC<=0, HALTED<=0, go to FETCH.
  - START=1 with LD_EN=1: the load wins and START is ignored.
- FETCH: IM_A=PC, IM_WR=0; go to DECODE.
- DECODE: IM_A=PC held; IR<=IM_Q; go to ISSUE.
- ISSUE:
  - VALID=1, all outputs decoded from IR; IM_A=PC held.
  - On an edge with EX_READY=1, compute next PC:
    - BRZ with ZERO=1: {DR,SB}.
    - JUMP: JMP_ADDR.
    - Otherwise: PC+1.
  - Then go to FETCH.
- Wrap-around: a sequential (non-taken) advance from PC=15 does not wrap. The block goes to IDLE with HALTED<=1 and PC<=0. A taken BRZ or JUMP from PC=15 proceeds normally.
- LD_EN and START outside IDLE are ignored; the memory is never written while executing.
- HALTED stays 1 until RST or the next accepted START.

## Timing
- Reset values: state IDLE, PC=0, IR=0, VALID=0, REG_WR=0, MEM_WR=0, ILLEGAL=0, HALTED=0, IM_WR=0, IM_A=0.
- RST has priority over every other input. Asserted in any state, including ISSUE with EX_READY=1, no PC update occurs and all reset values appear after that edge.
- START sampled at edge e0 leads to:
  - FETCH in cycle after e0.
  - DECODE after e1.
  - VALID=1 after e2.
- Accept happens at the first edge with VALID=1 and EX_READY=1. VALID drops after it.
- Throughput: one instruction per 3 cycles with EX_READY tied high.
- Stall: while EX_READY=0, VALID, all decoded outputs, PC and IM_A hold unchanged indefinitely.
- ZERO and JMP_ADDR are don't-care except on the accept edge of BRZ or JUMP.

## Test plan
- Reset, then load 0000010_11_11_00 at address 0 via LD_EN, then START with EX_READY=1 -> VALID rises 3 edges after START; OP_CLASS=1, DR=3, SA=3, SB=0, REG_WR=1, MEM_WR=0; next IM_A=1.
- BRZ 1100000_10_01_11 at PC=0 -> with ZERO=1, next fetch IM_A=11 (1011); repeat with ZERO=0, next IM_A=1.
- JUMP 1110000_00_10_00 with JMP_ADDR=5 on the accept edge -> next fetch IM_A=5, PC=5.
- STORE 0100000_00_10_11 with EX_READY held low 4 cycles -> VALID=1, MEM_WR=1, SA=2, SB=3, PC and IM_A constant throughout; advances one edge after EX_READY rises.
- Program of NOPs ending at address 15 -> after accepting PC=15: VALID=0, HALTED=1, state IDLE, PC=0. Separately, opcode 1111111 -> ILLEGAL=1, OP_CLASS=0, REG_WR=0, PC+1.
- RST asserted in ISSUE with EX_READY=1 -> next cycle VALID=0, PC=0, IM_A=0, HALTED=0. Also check LD_EN asserted during FETCH -> IM_WR stays 0.
